// File: rtl/inst_encoder.sv
// Two-stage RV32I instruction encoder: stage A registers the decoded fields, stage B holds the packed word.
// Optional CSR-format support is enabled with `define INST_ENCODER_CSR_EN.
module inst_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [6:0]       req_opcode,
  input  logic [4:0]       req_rda,
  input  logic [4:0]       req_r1a,
  input  logic [4:0]       req_r2a,
  input  logic [2:0]       req_funct3,
  input  logic             req_funct7_1bit,
  input  logic [31:0]      req_imm,
`ifdef INST_ENCODER_CSR_EN
  input  logic [11:0]      req_csr_addr,
`endif
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [31:0]      inst,
  output logic             inst_err,
  output logic [CNT_W-1:0] enc_count
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rda;
    logic [4:0]  r1a;
    logic [4:0]  r2a;
    logic [2:0]  funct3;
    logic        f7;
    logic [31:0] imm;
  } req_t;

  req_t             a_q;
  logic             a_valid_q;
  logic             b_valid_q;
  logic [31:0]      inst_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;
`ifdef INST_ENCODER_CSR_EN
  logic [11:0]      a_csr_q;
`endif

  logic        a_load, b_take, handoff;
  logic [31:0] enc_inst;
  logic        enc_err;

  // A may refill whenever it is empty or its word is about to move into B.
  assign req_ready = rstn & (!a_valid_q | !b_valid_q | inst_ready);
  assign a_load    = req_valid & req_ready;
  assign b_take    = a_valid_q & (!b_valid_q | inst_ready);
  assign handoff   = b_valid_q & inst_ready;

  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rstn) begin
      a_q       <= '0;
      a_valid_q <= 1'b0;
      b_valid_q <= 1'b0;
      inst_q    <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
`ifdef INST_ENCODER_CSR_EN
      a_csr_q   <= '0;
`endif
    end else begin
      if (a_load) begin
        a_q <= '{opcode: req_opcode, rda: req_rda, r1a: req_r1a, r2a: req_r2a,
                 funct3: req_funct3, f7: req_funct7_1bit, imm: req_imm};
`ifdef INST_ENCODER_CSR_EN
        a_csr_q <= req_csr_addr;
`endif
      end
      if (a_load)      a_valid_q <= 1'b1;
      else if (b_take) a_valid_q <= 1'b0;

      if (b_take) begin
        b_valid_q <= 1'b1;
        inst_q    <= enc_inst;
        err_q     <= enc_err;
      end else if (handoff) begin
        b_valid_q <= 1'b0;
      end

      if (handoff) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Immediate fits when the bits above the field are a pure sign extension.
  logic imm_i_ok, imm_b_ok, imm_j_ok;
  assign imm_i_ok = (&a_q.imm[31:11]) | ~(|a_q.imm[31:11]);
  assign imm_b_ok = ((&a_q.imm[31:12]) | ~(|a_q.imm[31:12])) & ~a_q.imm[0];
  assign imm_j_ok = ((&a_q.imm[31:20]) | ~(|a_q.imm[31:20])) & ~a_q.imm[0];

  always_comb begin
    // NOTE: defaults first so no path through this block can infer a latch.
    enc_inst = NOP;
    enc_err  = 1'b0;
    unique case (a_q.opcode)
      7'b0110011: enc_inst = {1'b0, a_q.f7, 5'b0, a_q.r2a, a_q.r1a, a_q.funct3, a_q.rda, a_q.opcode};
      7'b0010011: begin
        if (a_q.funct3[1:0] == 2'b01) begin
          enc_err  = |a_q.imm[31:5];
          enc_inst = {1'b0, a_q.f7, 5'b0, a_q.imm[4:0], a_q.r1a, a_q.funct3, a_q.rda, a_q.opcode};
        end else begin
          enc_err  = !imm_i_ok;
          enc_inst = {a_q.imm[11:0], a_q.r1a, a_q.funct3, a_q.rda, a_q.opcode};
        end
      end
      7'b0000011, 7'b1100111: begin
        enc_err  = !imm_i_ok;
        enc_inst = {a_q.imm[11:0], a_q.r1a, a_q.funct3, a_q.rda, a_q.opcode};
      end
      7'b0100011: begin
        enc_err  = !imm_i_ok;
        enc_inst = {a_q.imm[11:5], a_q.r2a, a_q.r1a, a_q.funct3, a_q.imm[4:0], a_q.opcode};
      end
      7'b1100011: begin
        enc_err  = !imm_b_ok;
        enc_inst = {a_q.imm[12], a_q.imm[10:5], a_q.r2a, a_q.r1a, a_q.funct3,
                    a_q.imm[4:1], a_q.imm[11], a_q.opcode};
      end
      7'b0110111, 7'b0010111: begin
        enc_err  = |a_q.imm[11:0];
        enc_inst = {a_q.imm[31:12], a_q.rda, a_q.opcode};
      end
      7'b1101111: begin
        enc_err  = !imm_j_ok;
        enc_inst = {a_q.imm[20], a_q.imm[10:1], a_q.imm[11], a_q.imm[19:12], a_q.rda, a_q.opcode};
      end
`ifdef INST_ENCODER_CSR_EN
      7'b1110011: begin
        enc_err  = (a_q.funct3[1:0] == 2'b00);
        enc_inst = {a_csr_q, a_q.r1a, a_q.funct3, a_q.rda, a_q.opcode};
      end
`endif
      default: enc_err = 1'b1;
    endcase
    if (enc_err) enc_inst = NOP;
  end

  assign inst_valid = b_valid_q;
  assign inst       = inst_q;
  assign inst_err   = err_q;
  assign enc_count  = cnt_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed self-checking bench for inst_encoder (CNT_W=4 so the counter wrap is reachable).
// Define INST_ENCODER_CSR_EN for both bench and RTL to exercise the CSR format.
module tb_inst_encoder;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rstn;
  logic             req_valid;
  logic             req_ready;
  logic [6:0]       req_opcode;
  logic [4:0]       req_rda, req_r1a, req_r2a;
  logic [2:0]       req_funct3;
  logic             req_funct7_1bit;
  logic [31:0]      req_imm;
`ifdef INST_ENCODER_CSR_EN
  logic [11:0]      req_csr_addr;
`endif
  logic             inst_valid;
  logic             inst_ready;
  logic [31:0]      inst;
  logic             inst_err;
  logic [CNT_W-1:0] enc_count;

  int               n_checks = 0;
  int               n_errors = 0;
  logic [CNT_W-1:0] exp_cnt  = '0;

  always #5 clk = ~clk;

  inst_encoder #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_rda(req_rda), .req_r1a(req_r1a), .req_r2a(req_r2a),
    .req_funct3(req_funct3), .req_funct7_1bit(req_funct7_1bit), .req_imm(req_imm),
`ifdef INST_ENCODER_CSR_EN
    .req_csr_addr(req_csr_addr),
`endif
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_err(inst_err), .enc_count(enc_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_req(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] r1,
                         input logic [4:0] r2, input logic [2:0] f3, input logic f7,
                         input logic [31:0] imm, input logic [11:0] csr);
    req_opcode = op; req_rda = rd; req_r1a = r1; req_r2a = r2;
    req_funct3 = f3; req_funct7_1bit = f7; req_imm = imm;
`ifdef INST_ENCODER_CSR_EN
    req_csr_addr = csr;
`else
    if (csr != 12'h0) begin end
`endif
  endtask

  // One request with inst_ready high: wait for acceptance, then for the word, then hand it off.
  task automatic xact(input string tag, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] r1, input logic [4:0] r2, input logic [2:0] f3,
                      input logic f7, input logic [31:0] imm, input logic [11:0] csr,
                      input logic [31:0] exp_inst, input logic exp_err);
    int n;
    @(negedge clk);
    set_req(op, rd, r1, r2, f3, f7, imm, csr);
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) check({tag, "_accept_timeout"}, 0, 1);
    @(posedge clk); #1 req_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!inst_valid && n < 20) begin @(negedge clk); n++; end
    if (!inst_valid) check({tag, "_valid_timeout"}, 0, 1);
    check({tag, "_inst"}, inst, exp_inst);
    check({tag, "_err"}, {31'b0, inst_err}, {31'b0, exp_err});
    @(posedge clk);
    if (inst_valid && inst_ready) exp_cnt++;
  endtask

  initial begin
    rstn = 1'b0; req_valid = 1'b0; inst_ready = 1'b1;
    set_req('0, '0, '0, '0, '0, 1'b0, '0, '0);
    #12;
    check("rst_valid", {31'b0, inst_valid}, 0);
    check("rst_inst", inst, 0);
    check("rst_err", {31'b0, inst_err}, 0);
    check("rst_cnt", {28'b0, enc_count}, 0);
    check("rst_ready", {31'b0, req_ready}, 0);
    @(negedge clk); rstn = 1'b1;

    xact("add",   7'h33, 5'd3, 5'd1, 5'd2, 3'b000, 1'b0, 32'd0, 12'h0, 32'h002081B3, 1'b0);
    xact("sub",   7'h33, 5'd3, 5'd1, 5'd2, 3'b000, 1'b1, 32'd0, 12'h0, 32'h402081B3, 1'b0);
    xact("addi",  7'h13, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, -32'sd1, 12'h0, 32'hFFF00093, 1'b0);
    xact("addi_min", 7'h13, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, -32'sd2048, 12'h0, 32'h80000093, 1'b0);
    xact("addi_ovf", 7'h13, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd2048, 12'h0, 32'h00000013, 1'b1);
    xact("lui",   7'h37, 5'd5, 5'd0, 5'd0, 3'b000, 1'b0, 32'h12345000, 12'h0, 32'h123452B7, 1'b0);
    xact("lui_bad", 7'h37, 5'd5, 5'd0, 5'd0, 3'b000, 1'b0, 32'h12345001, 12'h0, 32'h00000013, 1'b1);
    xact("sw",    7'h23, 5'd0, 5'd1, 5'd2, 3'b010, 1'b0, 32'd4, 12'h0, 32'h0020A223, 1'b0);
    xact("srai",  7'h13, 5'd1, 5'd2, 5'd0, 3'b101, 1'b1, 32'd3, 12'h0, 32'h40315093, 1'b0);
    xact("srai_32", 7'h13, 5'd1, 5'd2, 5'd0, 3'b101, 1'b1, 32'd32, 12'h0, 32'h00000013, 1'b1);
    xact("beq",   7'h63, 5'd0, 5'd1, 5'd2, 3'b000, 1'b0, 32'd8, 12'h0, 32'h00208463, 1'b0);
    xact("beq_odd", 7'h63, 5'd0, 5'd1, 5'd2, 3'b000, 1'b0, 32'd3, 12'h0, 32'h00000013, 1'b1);
    xact("beq_4096", 7'h63, 5'd0, 5'd1, 5'd2, 3'b000, 1'b0, 32'd4096, 12'h0, 32'h00000013, 1'b1);
    xact("beq_min", 7'h63, 5'd0, 5'd1, 5'd2, 3'b000, 1'b0, -32'sd4096, 12'h0, 32'h80208063, 1'b0);
    xact("jal",   7'h6F, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd8, 12'h0, 32'h008000EF, 1'b0);
    xact("jal_odd", 7'h6F, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd9, 12'h0, 32'h00000013, 1'b1);
    xact("bad_op", 7'h7F, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd0, 12'h0, 32'h00000013, 1'b1);
`ifdef INST_ENCODER_CSR_EN
    xact("csrrw", 7'h73, 5'd1, 5'd2, 5'd0, 3'b001, 1'b0, 32'd0, 12'h300, 32'h300110F3, 1'b0);
    xact("csr_f3_0", 7'h73, 5'd1, 5'd2, 5'd0, 3'b000, 1'b0, 32'd0, 12'h300, 32'h00000013, 1'b1);
`else
    xact("csr_off", 7'h73, 5'd1, 5'd2, 5'd0, 3'b001, 1'b0, 32'd0, 12'h300, 32'h00000013, 1'b1);
`endif
    @(negedge clk);
    check("cnt_after_vectors", {28'b0, enc_count}, {28'b0, exp_cnt});

    // Latency: accept at one edge, A holds it, B shows it after the next edge.
    set_req(7'h13, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd5, 12'h0);
    req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    check("lat_not_yet", {31'b0, inst_valid}, 0);
    @(negedge clk);
    check("lat_valid", {31'b0, inst_valid}, 1);
    check("lat_inst", inst, 32'h00500093);
    @(posedge clk); exp_cnt++;

    // Backpressure: three requests against a stalled output.
    @(negedge clk);
    inst_ready = 1'b0;
    set_req(7'h13, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, -32'sd1, 12'h0);
    req_valid = 1'b1;
    @(negedge clk);
    check("bp_ready1", {31'b0, req_ready}, 1);
    set_req(7'h33, 5'd3, 5'd1, 5'd2, 3'b000, 1'b0, 32'd0, 12'h0);
    @(negedge clk);
    set_req(7'h37, 5'd5, 5'd0, 5'd0, 3'b000, 1'b0, 32'h12345000, 12'h0);
    check("bp_ready3", {31'b0, req_ready}, 0);
    check("bp_inst_w1", inst, 32'hFFF00093);
    repeat (2) @(negedge clk);
    check("bp_hold_valid", {31'b0, inst_valid}, 1);
    check("bp_hold_inst", inst, 32'hFFF00093);
    check("bp_hold_ready", {31'b0, req_ready}, 0);
    inst_ready = 1'b1;
    #1 check("bp_ready_comb", {31'b0, req_ready}, 1);
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    check("bp_w2", inst, 32'h002081B3);
    check("bp_w2_valid", {31'b0, inst_valid}, 1);
    @(negedge clk);
    check("bp_w3", inst, 32'h123452B7);
    check("bp_w3_valid", {31'b0, inst_valid}, 1);
    @(negedge clk);
    check("bp_drained", {31'b0, inst_valid}, 0);
    exp_cnt = exp_cnt + 4'd3;
    check("bp_cnt", {28'b0, enc_count}, {28'b0, exp_cnt});

    // Reset with two words in flight.
    inst_ready = 1'b0;
    set_req(7'h13, 5'd2, 5'd0, 5'd0, 3'b000, 1'b0, 32'd1, 12'h0);
    req_valid = 1'b1;
    repeat (2) @(negedge clk);
    req_valid = 1'b0;
    check("mid_inflight", {31'b0, inst_valid}, 1);
    #2 rstn = 1'b0;
    #1;
    check("mid_rst_valid", {31'b0, inst_valid}, 0);
    check("mid_rst_cnt", {28'b0, enc_count}, 0);
    check("mid_rst_inst", inst, 0);
    check("mid_rst_ready", {31'b0, req_ready}, 0);
    @(negedge clk); rstn = 1'b1; inst_ready = 1'b1; exp_cnt = '0;
    repeat (2) @(negedge clk);
    check("mid_no_ghost", {31'b0, inst_valid}, 0);

    // Counter wrap: 17 handoffs on a 4-bit counter.
    for (int i = 0; i < 17; i++)
      xact("wrap", 7'h13, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd1, 12'h0, 32'h00100093, 1'b0);
    @(negedge clk);
    check("wrap_cnt", {28'b0, enc_count}, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
